// File: rtl/shift_sched_pkg.sv
// Shared widths and types for the shift scheduler and its barrel shifter.
package shift_sched_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              left;
    logic              is_signed;
  } shift_op_t;

endpackage

// File: rtl/barrel_shifter.sv
// One-cycle registered barrel shifter: SLL, SRL or SRA by 0..31 bits.
// The result register only loads when enabled, so it doubles as the response hold register.
module barrel_shifter
  import shift_sched_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  shift_op_t         i_op,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] stage;

  // log2 stages, each shifting by a power of two when its amount bit is set
  always_comb begin
    stage = i_op.data;
    for (int j = 0; j < AMT_W; j++) begin
      if (i_op.amt[j]) begin
        if (i_op.left) begin
          stage = stage << (1 << j);
        end else if (i_op.is_signed) begin
          stage = $signed(stage) >>> (1 << j);
        end else begin
          stage = stage >> (1 << j);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else if (i_en) begin
      o_data <= stage;
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Round-robin scheduler that shares one barrel shifter between N_REQ requesters.
// state | meaning
// IDLE  | waiting for a request and a free response slot; grant happens here
// SHIFT | latched op is on the shifter; result and id captured on the next edge
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_REQ-1:0]             i_req_valid,
  output logic [N_REQ-1:0]             o_req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0] i_req_data,
  input  logic [N_REQ-1:0][AMT_W-1:0]  i_req_amt,
  input  logic [N_REQ-1:0]             i_req_left,
  input  logic [N_REQ-1:0]             i_req_signed,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [DATA_W-1:0]            o_rsp_data,
  output logic [ID_W-1:0]              o_rsp_id,
  output logic                         o_busy,
  output logic [15:0]                  o_ops_done
);

  state_t          state;
  shift_op_t       op_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;
  logic            win_found;
  logic            grant;
  logic            retire;
  logic            armed;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     ops_done_q;

  // Search starts one past the last winner and wraps at N_REQ (N_REQ need not be a power of two)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last_grant;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && i_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // armed keeps grants off until the first edge after reset release
  assign grant  = (state == IDLE) && armed && win_found && (!rsp_valid_q || i_rsp_ready);
  assign retire = rsp_valid_q && i_rsp_ready;

  always_comb begin
    o_req_ready = '0;
    if (grant) begin
      o_req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      id_q        <= '0;
      last_grant  <= ID_W'(N_REQ - 1);
      armed       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      ops_done_q  <= '0;
    end else begin
      armed <= 1'b1;
      if (retire) begin
        rsp_valid_q <= 1'b0;
        ops_done_q  <= ops_done_q + 16'd1;
      end
      case (state)
        IDLE: begin
          if (grant) begin
            op_q.data      <= i_req_data[win_idx];
            op_q.amt       <= i_req_amt[win_idx];
            op_q.left      <= i_req_left[win_idx];
            op_q.is_signed <= i_req_signed[win_idx];
            id_q           <= win_idx;
            last_grant     <= win_idx;
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          // the slot was freed at grant, so this capture never collides with a retire
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  barrel_shifter u_shifter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (state == SHIFT),
    .i_op    (op_q),
    .o_data  (o_rsp_data)
  );

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_ops_done  = ops_done_q;
  assign o_busy      = (state != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Self-checking bench for shift_scheduler: vector table, directed corner sequences, random traffic vs. model.
module tb_shift_scheduler;

  localparam int N = 4;

  logic              i_clk;
  logic              i_rst_n;
  logic [N-1:0]      i_req_valid;
  logic [N-1:0]      o_req_ready;
  logic [N-1:0][31:0] i_req_data;
  logic [N-1:0][4:0] i_req_amt;
  logic [N-1:0]      i_req_left;
  logic [N-1:0]      i_req_signed;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_rsp_data;
  logic [1:0]        o_rsp_id;
  logic              o_busy;
  logic [15:0]       o_ops_done;

  int errors = 0;
  int checks = 0;

  shift_scheduler #(.N_REQ(N)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_data   (i_req_data),
    .i_req_amt    (i_req_amt),
    .i_req_left   (i_req_left),
    .i_req_signed (i_req_signed),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_id     (o_rsp_id),
    .o_busy       (o_busy),
    .o_ops_done   (o_ops_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    int          req;
    logic [31:0] data;
    int          amt;
    bit          left;
    bit          sgn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Shifts expressed as multiply/divide by 2**amt on a 64-bit sign- or zero-extended operand
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt, input bit left, input bit sgn);
    logic [63:0] p;
    logic [63:0] w;
    p = 64'd1 << amt;
    if (left)                w = {32'd0, d} * p;
    else if (sgn && d[31])   w = {32'hFFFF_FFFF, d} / p;
    else                     w = {32'd0, d} / p;
    return w[31:0];
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_reqs();
    i_req_valid  = '0;
    i_req_data   = '0;
    i_req_amt    = '0;
    i_req_left   = '0;
    i_req_signed = '0;
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    clear_reqs();
    i_rsp_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  // Entered just after a rising edge; returns at the falling edge of the grant cycle (idx -1 on timeout)
  task automatic wait_grant(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      if (o_req_ready != '0) begin
        idx = onehot_idx(o_req_ready);
        return;
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int idx;
    int lat;
    clear_reqs();
    i_req_data[v.req]   = v.data;
    i_req_amt[v.req]    = 5'(v.amt);
    i_req_left[v.req]   = v.left;
    i_req_signed[v.req] = v.sgn;
    i_req_valid[v.req]  = 1'b1;
    i_rsp_ready = 1'b1;
    wait_grant(8, idx);
    chk({tag, " grant"}, 32'(idx), 32'(v.req));
    @(posedge i_clk); #1;
    i_req_valid = '0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd2);
    chk({tag, " data"}, o_rsp_data, v.exp);
    chk({tag, " id"}, 32'(o_rsp_id), 32'(v.req));
    @(posedge i_clk); #1;
  endtask

  int gid[5];
  int gat[5];
  int ng;
  int idx;
  bit saw_rsp;
  int first;

  // random-phase model state
  bit          m_inflight;
  logic [31:0] m_op_data;
  int          m_op_amt;
  bit          m_op_left;
  bit          m_op_sgn;
  int          m_op_id;
  bit          m_rsp_valid;
  logic [31:0] m_rsp_data;
  int          m_rsp_id;
  int          m_last;
  logic [15:0] m_ops;

  initial begin
    vecs[0] = '{0, 32'h8000_00F0,  4, 1'b0, 1'b1, 32'hF800_000F};
    vecs[1] = '{1, 32'hFFFF_FFFF, 31, 1'b1, 1'b0, 32'h8000_0000};
    vecs[2] = '{2, 32'h1234_5678,  0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[3] = '{3, 32'hFFFF_FFFF, 31, 1'b0, 1'b0, 32'h0000_0001};
    vecs[4] = '{0, 32'h8000_0000, 31, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{1, 32'h0000_F00F,  8, 1'b1, 1'b0, 32'h00F0_0F00};
    vecs[6] = '{2, 32'hA5A5_A5A5,  0, 1'b0, 1'b1, 32'hA5A5_A5A5};
    vecs[7] = '{3, 32'h7FFF_FFFF, 30, 1'b0, 1'b1, 32'h0000_0001};

    // outputs held at zero during reset even with every request up
    i_rst_n = 1'b0;
    clear_reqs();
    i_req_valid = '1;
    i_rsp_ready = 1'b1;
    #7;
    chk("rst ready", 32'(o_req_ready), 32'd0);
    chk("rst rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst data", o_rsp_data, 32'd0);
    chk("rst id", 32'(o_rsp_id), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst ops", 32'(o_ops_done), 32'd0);

    do_reset();
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    chk("ops after vectors", 32'(o_ops_done), 32'd8);

    // fairness: every requester up, consumer always ready
    do_reset();
    i_req_valid = '1;
    for (int i = 0; i < N; i++) i_req_data[i] = 32'(i + 1);
    for (int i = 0; i < 5; i++) begin gid[i] = -1; gat[i] = -100; end
    ng = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_req_ready != '0) begin
        gid[ng] = onehot_idx(o_req_ready);
        gat[ng] = c;
        ng++;
      end
      if (ng == 5) break;
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_req_valid = '0;
    chk("fair count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("fair order%0d", i), 32'(gid[i]), 32'(i % N));
    for (int i = 0; i < 4; i++) chk($sformatf("fair gap%0d", i), 32'(gat[i+1] - gat[i]), 32'd2);
    repeat (4) @(posedge i_clk);
    #1;

    // backpressure: response held for 10 cycles, competing request waits
    clear_reqs();
    i_rsp_ready = 1'b0;
    i_req_data[1] = 32'h0000_1234; i_req_amt[1] = 5'd4; i_req_left[1] = 1'b1;
    i_req_valid[1] = 1'b1;
    wait_grant(8, idx);
    chk("bp grant", 32'(idx), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 4'b0100;
    i_req_data[2] = 32'hF000_0000; i_req_amt[2] = 5'd4; i_req_signed[2] = 1'b1;
    @(negedge i_clk);
    chk("bp shift ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk("bp hold valid", 32'(o_rsp_valid), 32'd1);
      chk("bp hold data", o_rsp_data, 32'h0001_2340);
      chk("bp hold id", 32'(o_rsp_id), 32'd1);
      chk("bp hold ready", 32'(o_req_ready), 32'd0);
      @(posedge i_clk); #1;
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("bp release grant", 32'(o_req_ready), 32'h4);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    @(negedge i_clk);
    chk("bp retired", 32'(o_rsp_valid), 32'd0);
    @(negedge i_clk);
    chk("bp next valid", 32'(o_rsp_valid), 32'd1);
    chk("bp next data", o_rsp_data, 32'hFF00_0000);
    chk("bp next id", 32'(o_rsp_id), 32'd2);
    @(posedge i_clk); #1;

    // reset while the op is in SHIFT
    clear_reqs();
    i_req_data[3] = 32'hDEAD_BEEF; i_req_amt[3] = 5'd3;
    i_req_valid[3] = 1'b1;
    wait_grant(8, idx);
    chk("rs grant", 32'(idx), 32'd3);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_req_valid = '1;
    #1;
    chk("rs ready", 32'(o_req_ready), 32'd0);
    chk("rs rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rs data", o_rsp_data, 32'd0);
    chk("rs id", 32'(o_rsp_id), 32'd0);
    chk("rs busy", 32'(o_busy), 32'd0);
    chk("rs ops", 32'(o_ops_done), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    saw_rsp = 1'b0;
    first = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid) saw_rsp = 1'b1;
      if (o_req_ready != '0) begin
        first = onehot_idx(o_req_ready);
        break;
      end
      @(posedge i_clk); #1;
    end
    chk("rs no response", 32'(saw_rsp), 32'd0);
    chk("rs first grant", 32'(first), 32'd0);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    repeat (4) @(posedge i_clk);
    #1;

    // counter wrap from a forced 0xFFFF
    force dut.ops_done_q = 16'hFFFF;
    #1;
    release dut.ops_done_q;
    run_vec(vecs[2], "wrap");
    chk("ops wrap", 32'(o_ops_done), 32'd0);

    // random traffic against the transaction model
    do_reset();
    m_inflight = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_id = 0;
    m_last = N - 1; m_ops = '0;
    m_op_data = '0; m_op_amt = 0; m_op_left = 1'b0; m_op_sgn = 1'b0; m_op_id = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int w;
      bit g;
      @(posedge i_clk); #1;
      for (int i = 0; i < N; i++) begin
        int r;
        i_req_valid[i]  = ($urandom_range(0, 99) < 40);
        i_req_data[i]   = $urandom;
        r = $urandom_range(0, 9);
        i_req_amt[i]    = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
        i_req_left[i]   = 1'($urandom_range(0, 1));
        i_req_signed[i] = 1'($urandom_range(0, 1));
      end
      i_rsp_ready = ($urandom_range(0, 99) < 65);
      @(negedge i_clk);
      w = rr_pick(i_req_valid, m_last);
      g = !m_inflight && (w >= 0) && (!m_rsp_valid || i_rsp_ready);
      chk("rnd ready", 32'(o_req_ready), g ? (32'd1 << w) : 32'd0);
      chk("rnd rsp_valid", 32'(o_rsp_valid), 32'(m_rsp_valid));
      if (m_rsp_valid) begin
        chk("rnd data", o_rsp_data, m_rsp_data);
        chk("rnd id", 32'(o_rsp_id), 32'(m_rsp_id));
      end
      chk("rnd ops", 32'(o_ops_done), 32'(m_ops));
      chk("rnd busy", 32'(o_busy), 32'(m_inflight || m_rsp_valid));
      if (m_rsp_valid && i_rsp_ready) begin
        m_rsp_valid = 1'b0;
        m_ops = m_ops + 16'd1;
      end
      if (m_inflight) begin
        m_rsp_valid = 1'b1;
        m_rsp_data  = ref_shift(m_op_data, m_op_amt, m_op_left, m_op_sgn);
        m_rsp_id    = m_op_id;
        m_inflight  = 1'b0;
      end
      if (g) begin
        m_inflight = 1'b1;
        m_op_data  = i_req_data[w];
        m_op_amt   = int'(i_req_amt[w]);
        m_op_left  = i_req_left[w];
        m_op_sgn   = i_req_signed[w];
        m_op_id    = w;
        m_last     = w;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
